// File: rtl/multi_cycle_control.sv
// Multi-cycle control unit for a MIPS-subset CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives ALU opcode,
// datapath mux selects and write enables from the registered state and IR fields.
// Optional feature: define MCC_BLTZ_EN to decode opcode 000001 as bltz
// (branch when the ALU result sign is 1); otherwise that opcode is illegal.
module multi_cycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       sign,
   output logic [2:0] ALUop,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic       RegDst,
   output logic       DBDataSrc,
   output logic       RegWre,
   output logic       mWR,
   output logic       mRD,
   output logic       IRWre,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BLTZ  = 6'b000001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_e state_q, state_d;

   logic [2:0] dec_alu_op_s;
   logic       dec_src_a_s;
   logic       dec_src_b_s;
   logic       dec_ext_s;
   logic       dec_legal_s;
   logic       is_r_s;
   logic       is_lw_s;
   logic       is_sw_s;
   logic       is_br_s;
   logic       is_j_s;
   logic       is_halt_s;
   logic       br_taken_s;

   // Instruction decode: ALU controls, instruction class and branch outcome from IR fields and flags
   always_comb begin
      dec_alu_op_s = 3'b000;
      dec_src_a_s  = 1'b0;
      dec_src_b_s  = 1'b0;
      dec_ext_s    = 1'b0;
      dec_legal_s  = 1'b0;
      is_r_s       = 1'b0;
      is_lw_s      = 1'b0;
      is_sw_s      = 1'b0;
      is_br_s      = 1'b0;
      is_j_s       = 1'b0;
      is_halt_s    = 1'b0;
      br_taken_s   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            is_r_s = 1'b1;
            case (funct)
               FN_ADD: begin dec_alu_op_s = 3'b010; dec_legal_s = 1'b1; end
               FN_SUB: begin dec_alu_op_s = 3'b110; dec_legal_s = 1'b1; end
               FN_AND: begin dec_alu_op_s = 3'b000; dec_legal_s = 1'b1; end
               FN_OR:  begin dec_alu_op_s = 3'b001; dec_legal_s = 1'b1; end
               FN_SLT: begin dec_alu_op_s = 3'b111; dec_legal_s = 1'b1; end
               FN_SLL: begin
                  dec_alu_op_s = 3'b011;
                  dec_src_a_s  = 1'b1;
                  dec_legal_s  = 1'b1;
               end
               default: dec_legal_s = 1'b0;
            endcase
         end
         OP_ADDI: begin
            dec_alu_op_s = 3'b010; dec_src_b_s = 1'b1; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
         end
         OP_ORI: begin
            dec_alu_op_s = 3'b001; dec_src_b_s = 1'b1; dec_ext_s = 1'b0; dec_legal_s = 1'b1;
         end
         OP_LW: begin
            dec_alu_op_s = 3'b010; dec_src_b_s = 1'b1; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
            is_lw_s = 1'b1;
         end
         OP_SW: begin
            dec_alu_op_s = 3'b010; dec_src_b_s = 1'b1; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
            is_sw_s = 1'b1;
         end
         OP_BEQ: begin
            dec_alu_op_s = 3'b110; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
            is_br_s = 1'b1; br_taken_s = zero;
         end
         OP_BNE: begin
            dec_alu_op_s = 3'b110; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
            is_br_s = 1'b1; br_taken_s = ~zero;
         end
`ifdef MCC_BLTZ_EN
         OP_BLTZ: begin
            // rs + $0 through the adder; the result sign tells whether rs < 0
            dec_alu_op_s = 3'b010; dec_ext_s = 1'b1; dec_legal_s = 1'b1;
            is_br_s = 1'b1; br_taken_s = sign;
         end
`else
         OP_BLTZ: dec_legal_s = 1'b0;
`endif
         OP_J:    begin is_j_s = 1'b1; dec_legal_s = 1'b1; end
         OP_HALT: begin is_halt_s = 1'b1; dec_legal_s = 1'b1; end
         default: dec_legal_s = 1'b0;
      endcase
   end

   // State register with synchronous reset back to instruction fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state outputs; ALU controls stay valid from EXE through WB
   always_comb begin
      state_d   = state_q;
      ALUop     = 3'b000;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      RegDst    = 1'b0;
      DBDataSrc = 1'b0;
      RegWre    = 1'b0;
      mWR       = 1'b0;
      mRD       = 1'b0;
      IRWre     = 1'b0;
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      illegal   = 1'b0;
      case (state_q)
         S_IF: begin
            IRWre   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            ExtSel = dec_ext_s;
            if (!dec_legal_s) begin
               illegal = 1'b1;
               PCWre   = 1'b1;
               PCSrc   = 2'b00;
               state_d = S_IF;
            end else if (is_j_s) begin
               PCWre   = 1'b1;
               PCSrc   = 2'b10;
               state_d = S_IF;
            end else if (is_halt_s) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            ALUop   = dec_alu_op_s;
            ALUSrcA = dec_src_a_s;
            ALUSrcB = dec_src_b_s;
            ExtSel  = dec_ext_s;
            if (is_br_s) begin
               PCWre   = 1'b1;
               PCSrc   = br_taken_s ? 2'b01 : 2'b00;
               state_d = S_IF;
            end else if (is_lw_s || is_sw_s) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALUop   = dec_alu_op_s;
            ALUSrcA = dec_src_a_s;
            ALUSrcB = dec_src_b_s;
            ExtSel  = dec_ext_s;
            if (is_lw_s) begin
               mRD     = 1'b1;
               state_d = S_WB;
            end else begin
               mWR     = 1'b1;
               PCWre   = 1'b1;
               state_d = S_IF;
            end
         end
         S_WB: begin
            ALUop     = dec_alu_op_s;
            ALUSrcA   = dec_src_a_s;
            ALUSrcB   = dec_src_b_s;
            ExtSel    = dec_ext_s;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
            RegDst    = is_r_s;
            DBDataSrc = is_lw_s;
            state_d   = S_IF;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IF;
         end
      endcase
   end

   assign state = state_q;

endmodule
